adder_multiword_seq: RTL and testbench
======================================

// Module: adder_multiword_seq
// PURPOSE
//  Sequential multi-word adder built on the combinational adder_xbit_serial.
//  Accepts a packet of DATA_WIDTH-bit operand beats (LSW first) over valid/ready.
//  Feeds each beat to one adder_xbit_serial instance, which adds it.
//  Registers the carry-out between beats and chains it into the next beat's carry-in.
//  Emits one registered sum beat per input beat. Sits between operand sources and the result sink.
// PARAMETERS
//  DATA_WIDTH  4   width of one operand/result beat
//  MAX_BEATS   8   max beats per packet; beat index width = $clog2(MAX_BEATS)
// PORTS
//  i_clk        in   1           single clock, rising edge
//  i_rst_n      in   1           asynchronous active-low reset
//  i_valid      in   1           input beat valid
//  o_ready      out  1           input beat accepted when i_valid & o_ready
//  i_num_a      in   DATA_WIDTH  operand A beat
//  i_num_b      in   DATA_WIDTH  operand B beat
//  i_cry        in   1           packet carry-in, used only on first beat
//  i_first      in   1           beat starts a new packet
//  i_last       in   1           beat ends the packet
//  o_valid      out  1           output beat valid
//  i_ready      in   1           downstream accepts when o_valid & i_ready
//  o_res        out  DATA_WIDTH  sum beat
//  o_cry        out  1           carry-out of this beat; meaningful as packet carry when o_last
//  o_last       out  1           output beat is packet end
//  o_beat_idx   out  $clog2(MAX_BEATS)  beat index within packet, 0 = first
//  o_err        out  1           one-cycle pulse on protocol error (see below)
// BEHAVIOUR
//  - Reset: o_valid=0, o_res=0, o_cry=0, o_last=0, o_beat_idx=0, o_err=0.
//    Reset also clears the carry register and beat counter to 0 and forces state IDLE.
//    Reset mid-packet discards the packet and any held output beat.
//  - States: IDLE (awaiting packet start) and BUSY (inside packet).
//  - Carry-in select: IDLE, or a beat with i_first set -> i_cry; BUSY without i_first -> carry register.
//  - On an accepted beat:
//    - o_res/o_cry are registered from the adder and o_valid=1. Latency 1 cycle; throughput 1 beat/cycle.
//    - The carry register loads the adder carry-out.
//    - o_beat_idx is loaded from the beat counter.
//    - The beat counter increments, or resets to 1 on a first beat.
//  - Transitions: IDLE->BUSY on an accepted beat without i_last.
//    BUSY->IDLE on an accepted beat with i_last. A beat with both first and last stays/returns IDLE.
//  - o_ready = !o_valid | i_ready, so one output stage with no bubbles.
//    When o_valid & !i_ready, all output regs hold.
//  - o_err pulses the cycle after an accepted beat when either:
//    - i_first arrives in BUSY: the old packet is abandoned and the beat is processed as a new first beat.
//    - The beat counter would reach MAX_BEATS without i_last: the beat is forced o_last=1 and state returns IDLE.
//  - Arithmetic is modulo 2^DATA_WIDTH per beat. The carry register holds exactly one bit.
//  - Carry does not leak between packets: the next packet always starts from i_cry.
// STRUCTURE
//  - Package adder_pkg: state enum {IDLE, BUSY}; function beat_idx_w(MAX_BEATS).
//  - Sub-module: one adder_xbit_serial #(.DATA_WIDTH) instance, combinational, fed from the input ports.
//  - Local logic: carry register, beat counter, FSM, output register stage.
// TESTING (DATA_WIDTH=4)
//  1. Single beat a=1100, b=1001, cry=0, first/last set -> o_res=0101, o_cry=1, o_last=1, idx=0.
//  2. 8-bit 0xFF+0x01 in 2 beats:
//     - beat0 F+1 gives o_res=0, o_cry=1.
//     - beat1 F+0 uses the chained carry and gives o_res=0, o_cry=1, o_last=1, idx=1.
//  3. Back-to-back packets, second has i_cry=1 (0101+0101): o_res=1011, o_cry=0.
//     No carry leaks from the previous packet and there are no idle cycles.
//  4. Hold i_ready=0 for 3 cycles mid-packet:
//     - o_ready=0 and the output is stable.
//     - No beat is lost or duplicated after release.
//     - The chained carry is still correct.
//  5. i_first in BUSY -> o_err pulse and the new packet sums correctly.
//     MAX_BEATS beats without i_last -> o_err, forced o_last.
//  6. Assert i_rst_n low mid-packet -> outputs return to reset values asynchronously.
//     The next packet starts at idx=0 with carry from i_cry.

Source files
------------

// File: rtl/adder_multiword_seq_pkg.sv
// Shared types and helpers for the multi-word sequential adder.
// Holds the packet FSM state and the beat-index width function.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int beat_idx_w(input int max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/adder_xbit_serial.sv
// Combinational ripple-carry adder for one operand beat.
// Carry ripples bit by bit from i_cry to o_cry.
module adder_xbit_serial #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);

  logic [DATA_WIDTH:0] w_c;

  always_comb begin
    w_c    = '0;
    o_res  = '0;
    w_c[0] = i_cry;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_res[i]  = i_num_a[i] ^ i_num_b[i] ^ w_c[i];
      w_c[i+1]  = (i_num_a[i] & i_num_b[i])
                | (w_c[i] & (i_num_a[i] ^ i_num_b[i]));
    end
    o_cry = w_c[DATA_WIDTH];
  end

endmodule

// File: rtl/adder_multiword_seq.sv
// Packet-based multi-word adder: one beat per cycle, carry chained
// between beats through a one-bit register, one registered output stage.
module adder_multiword_seq
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BEATS  = 8,
  localparam int IW = beat_idx_w(MAX_BEATS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  input  logic                  i_first,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry,
  output logic                  o_last,
  output logic [IW-1:0]         o_beat_idx,
  output logic                  o_err
);

  localparam int CW = IW + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_carry;
  logic [IW-1:0]         r_cnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_cry;
  logic                  r_last;
  logic [IW-1:0]         r_idx;
  logic                  r_err;

  logic                  w_ready;
  logic                  w_acc;
  logic                  w_start;
  logic                  w_cin;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_cout;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_ovf;
  logic                  w_abandon;
  logic                  w_last;
  logic [IW-1:0]         w_idx;

  // A beat in IDLE is always treated as the start of a packet.
  assign w_start   = (r_state == IDLE) | i_first;
  assign w_acc     = i_valid & w_ready;
  assign w_cin     = w_start ? i_cry : r_carry;
  assign w_cnt_nxt = w_start ? CW'(1) : {1'b0, r_cnt} + CW'(1);
  assign w_ovf     = (w_cnt_nxt == CW'(MAX_BEATS)) & ~i_last;
  assign w_abandon = i_first & (r_state == BUSY);
  assign w_last    = i_last | w_ovf;
  assign w_idx     = w_start ? '0 : r_cnt;

  adder_xbit_serial #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_add (
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .i_cry   (w_cin),
    .o_res   (w_sum),
    .o_cry   (w_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      w_state_nxt = w_last ? IDLE : BUSY;
    end
  end

  always_comb begin
    w_ready = ~r_valid | i_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_carry <= w_cout;
      r_cnt   <= w_cnt_nxt[IW-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_cry   <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_acc & (w_abandon | w_ovf);
      if (w_acc) begin
        r_valid <= 1'b1;
        r_res   <= w_sum;
        r_cry   <= w_cout;
        r_last  <= w_last;
        r_idx   <= w_idx;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_ready    = w_ready;
  assign o_valid    = r_valid;
  assign o_res      = r_res;
  assign o_cry      = r_cry;
  assign o_last     = r_last;
  assign o_beat_idx = r_idx;
  assign o_err      = r_err;

endmodule

// File: tb/tb_adder_multiword_seq.sv
// Self-checking bench for adder_multiword_seq (DATA_WIDTH=4, MAX_BEATS=8).
// Expected beats come from whole-packet integer addition.
module tb_adder_multiword_seq;

  localparam int DW = 4;
  localparam int MB = 8;
  localparam int IW = 3;

  typedef struct {
    logic [DW-1:0] res;
    logic          cry;
    logic          last;
    logic [IW-1:0] idx;
    int            cyc;
  } beat_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_num_a = '0;
  logic [DW-1:0] i_num_b = '0;
  logic          i_cry = 1'b0;
  logic          i_first = 1'b0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_res;
  logic          o_cry;
  logic          o_last;
  logic [IW-1:0] o_beat_idx;
  logic          o_err;

  int    vec = 0;
  int    errs = 0;
  int    cyc = 0;
  int    err_cnt = 0;
  bit    rnd_ready = 0;
  beat_t got_q[$];
  beat_t exp_q[$];

  adder_multiword_seq #(
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_num_a    (i_num_a),
    .i_num_b    (i_num_b),
    .i_cry      (i_cry),
    .i_first    (i_first),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_res      (o_res),
    .o_cry      (o_cry),
    .o_last     (o_last),
    .o_beat_idx (o_beat_idx),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      beat_t b;
      b.res  = o_res;
      b.cry  = o_cry;
      b.last = o_last;
      b.idx  = o_beat_idx;
      b.cyc  = cyc;
      got_q.push_back(b);
    end
    if (i_rst_n && o_err) err_cnt++;
  end

  always @(posedge i_clk) begin
    if (rnd_ready) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [8:0] pk(input beat_t x);
    return {x.res, x.cry, x.last, x.idx};
  endfunction

  // Reference: beat k is the k-th nibble of the full packet sum;
  // its carry is bit 4(k+1) of the sum of the low k+1 beats.
  task automatic model(input int n, input longint a, input longint b,
                       input bit cin, input bit closed);
    for (int k = 0; k < n; k++) begin
      beat_t  e;
      longint m;
      longint s;
      m      = longint'(1) << (DW * (k + 1));
      s      = (a % m) + (b % m) + longint'(cin);
      e.res  = DW'(s >> (DW * k));
      e.cry  = (s >= m);
      e.last = (closed && k == n - 1) || (k == MB - 1);
      e.idx  = IW'(k);
      e.cyc  = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic c, input logic f, input logic l);
    bit acc;
    int n;
    acc     = 0;
    n       = 0;
    i_valid = 1'b1;
    i_num_a = a;
    i_num_b = b;
    i_cry   = c;
    i_first = f;
    i_last  = l;
    while (!acc && n < 200) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
    vec++;
    if (!acc) begin
      errs++;
      $display("FAIL accept_timeout o_ready=%0b want 1", o_ready);
    end
  endtask

  task automatic send_pkt(input int n, input longint a, input longint b,
                          input bit cin, input bit closed);
    for (int k = 0; k < n; k++) begin
      send_beat(a[DW*k +: DW], b[DW*k +: DW], cin,
                (k == 0), closed && (k == n - 1));
    end
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    repeat (3) @(negedge i_clk);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    vec++;
    if ({o_valid, o_res, o_cry, o_last, o_beat_idx, o_err} !== 11'd0) begin
      errs++;
      $display("FAIL reset_outputs got %b want 0",
               {o_valid, o_res, o_cry, o_last, o_beat_idx, o_err});
    end
    vec++;
    if (o_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got %b want 1", o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_single();
    model(1, 64'hC, 64'h9, 1'b0, 1'b1);
    send_pkt(1, 64'hC, 64'h9, 1'b0, 1'b1);
    drain(exp_q.size());
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL single_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
    end
    if (got_q.size() > 0) begin
      vec++;
      if (pk(got_q[0]) !== 9'b0101_1_1_000) begin
        errs++;
        $display("FAIL single_literal got %b want 010111000", pk(got_q[0]));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_carry_chain();
    model(2, 64'hFF, 64'h01, 1'b0, 1'b1);
    send_pkt(2, 64'hFF, 64'h01, 1'b0, 1'b1);
    drain(exp_q.size());
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL chain_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL chain_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
    end
    if (got_q.size() > 1) begin
      vec++;
      if (pk(got_q[1]) !== 9'b0000_1_1_001) begin
        errs++;
        $display("FAIL chain_literal got %b want 000011001", pk(got_q[1]));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    model(2, 64'hFF, 64'h01, 1'b0, 1'b1);
    model(1, 64'h5, 64'h5, 1'b1, 1'b1);
    send_pkt(2, 64'hFF, 64'h01, 1'b0, 1'b1);
    send_pkt(1, 64'h5, 64'h5, 1'b1, 1'b1);
    drain(exp_q.size());
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL b2b_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
      if (i > 0) begin
        vec++;
        if (got_q[i].cyc - got_q[i-1].cyc != 1) begin
          errs++;
          $display("FAIL b2b_gap%0d got %0d want 1", i, got_q[i].cyc - got_q[i-1].cyc);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stall();
    longint a;
    longint b;
    a = longint'($urandom) & 64'hFFFF;
    b = longint'($urandom) & 64'hFFFF;
    model(4, a, b, 1'b1, 1'b1);
    i_ready = 1'b0;
    send_beat(a[3:0], b[3:0], 1'b1, 1'b1, 1'b0);
    i_valid = 1'b1;
    i_num_a = a[7:4];
    i_num_b = b[7:4];
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      vec++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
        errs++;
        $display("FAIL stall_ready%0d got rdy=%b vld=%b want 0/1", c, o_ready, o_valid);
      end
      vec++;
      if ({o_res, o_cry, o_last, o_beat_idx} !== pk(exp_q[0])) begin
        errs++;
        $display("FAIL stall_hold%0d got %b want %b", c,
                 {o_res, o_cry, o_last, o_beat_idx}, pk(exp_q[0]));
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      send_beat(a[DW*k +: DW], b[DW*k +: DW], 1'b0, 1'b0, k == 3);
    end
    drain(exp_q.size());
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL stall_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_errors();
    int e0;
    longint a;
    longint b;
    e0 = err_cnt;
    model(2, 64'h3A, 64'h7C, 1'b1, 1'b0);
    model(3, 64'h8F1, 64'h90E, 1'b0, 1'b1);
    send_pkt(2, 64'h3A, 64'h7C, 1'b1, 1'b0);
    send_pkt(3, 64'h8F1, 64'h90E, 1'b0, 1'b1);
    drain(exp_q.size());
    vec++;
    if (err_cnt - e0 != 1) begin
      errs++;
      $display("FAIL abandon_err got %0d want 1", err_cnt - e0);
    end
    a  = longint'($urandom);
    b  = longint'($urandom);
    e0 = err_cnt;
    model(MB, a, b, 1'b1, 1'b0);
    send_pkt(MB, a, b, 1'b1, 1'b0);
    drain(exp_q.size());
    vec++;
    if (err_cnt - e0 != 1) begin
      errs++;
      $display("FAIL overflow_err got %0d want 1", err_cnt - e0);
    end
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL err_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL err_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    send_pkt(2, 64'hFF, 64'hFF, 1'b1, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    vec++;
    if ({o_valid, o_res, o_cry, o_last, o_beat_idx, o_err} !== 11'd0) begin
      errs++;
      $display("FAIL midreset_outputs got %b want 0",
               {o_valid, o_res, o_cry, o_last, o_beat_idx, o_err});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    @(posedge i_clk);
    #1;
    model(2, 64'h28, 64'h19, 1'b1, 1'b1);
    send_beat(4'h8, 4'h9, 1'b1, 1'b0, 1'b0);
    send_beat(4'h2, 4'h1, 1'b0, 1'b0, 1'b1);
    drain(exp_q.size());
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL midreset_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL midreset_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int e0;
    e0 = err_cnt;
    rnd_ready = 1;
    for (int p = 0; p < 20; p++) begin
      int     n;
      bit     c;
      longint m;
      longint a;
      longint b;
      n = $urandom_range(1, MB);
      c = 1'($urandom_range(0, 1));
      m = (longint'(1) << (DW * n)) - 1;
      a = longint'($urandom) & m;
      b = longint'($urandom) & m;
      model(n, a, b, c, 1'b1);
      send_pkt(n, a, b, c, 1'b1);
    end
    drain(exp_q.size());
    rnd_ready = 0;
    @(posedge i_clk);
    #2;
    i_ready = 1'b1;
    vec++;
    if (err_cnt != e0) begin
      errs++;
      $display("FAIL random_err got %0d want 0", err_cnt - e0);
    end
    vec++;
    if (got_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec++;
      if (pk(got_q[i]) !== pk(exp_q[i])) begin
        errs++;
        $display("FAIL random_beat%0d got %b want %b", i, pk(got_q[i]), pk(exp_q[i]));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry_chain();
    test_back_to_back();
    test_stall();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
